// File: rtl/sha_miner_pkg.sv
// Shared defaults, serializer state type and helpers for the SHA job framer.
package sha_miner_pkg;

    localparam int HDR_BYTES_DEF    = 88;
    localparam int HASH_BYTES_DEF   = 80;
    localparam int TGT_OFS_DEF      = 80;
    localparam int JOBID_OFS_DEF    = 84;
    localparam int RES_BYTES_DEF    = 32;
    localparam int FIFO_DEPTH_DEF   = 16;
    localparam int CHECK_TARGET_DEF = 1;

    localparam logic [31:0] LAST_NONCE = 32'hFFFFFFFF;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } serState_e;

    // Header words are stored byte 0 in the low bits, but target and job ID are read MSB-first.
    function automatic logic [31:0] byteSwap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha_result_fifo.sv
// Synchronous show-ahead FIFO holding complete result records.
module sha_result_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr_q, wrPtr_d;
    logic [AW:0]      rdPtr_q, rdPtr_d;
    logic             doPush;
    logic             doPop;

    generate
        if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
            $error("sha_result_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign data_o  = mem[rdPtr_q[AW-1:0]];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) wrPtr_d = wrPtr_q + 1'b1;
        if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/sha_job_framer.sv
// Frames inbound work headers for the hash mix and serializes filtered results
// (plus work-request records) onto an outbound byte stream.
module sha_job_framer
    import sha_miner_pkg::*;
#(
    parameter int HDR_BYTES    = HDR_BYTES_DEF,
    parameter int HASH_BYTES   = HASH_BYTES_DEF,
    parameter int TGT_OFS      = TGT_OFS_DEF,
    parameter int JOBID_OFS    = JOBID_OFS_DEF,
    parameter int RES_BYTES    = RES_BYTES_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int CHECK_TARGET = CHECK_TARGET_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    output logic                    in_ready,
    output logic [HASH_BYTES*8-1:0] hash_data,
    output logic [31:0]             job_id,
    output logic                    start,
    input  logic                    res_valid,
    input  logic [RES_BYTES*8-1:0]  res_data,
    input  logic [31:0]             res_job,
    input  logic [31:0]             res_nonce,
    output logic                    out_valid,
    output logic [7:0]              out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [15:0]             drop_cnt
);

    localparam int WP_W = $clog2(HDR_BYTES);
    localparam int RP_W = $clog2(RES_BYTES);
    localparam logic [WP_W-1:0] HDR_LAST = WP_W'(HDR_BYTES - 1);
    localparam logic [RP_W-1:0] RES_LAST = RP_W'(RES_BYTES - 1);

    generate
        if (JOBID_OFS + 4 > HDR_BYTES) begin : g_bad_jobid
            $error("sha_job_framer: job ID field exceeds header");
        end
        if (TGT_OFS + 4 > HDR_BYTES) begin : g_bad_tgt
            $error("sha_job_framer: target field exceeds header");
        end
        if (HASH_BYTES > HDR_BYTES) begin : g_bad_hash
            $error("sha_job_framer: HASH_BYTES exceeds HDR_BYTES");
        end
        if (RES_BYTES < 8) begin : g_bad_res
            $error("sha_job_framer: RES_BYTES must be at least 8");
        end
    endgenerate

    logic [WP_W-1:0]          wrPtr_q, wrPtr_d;
    logic [HDR_BYTES*8-1:0]   stageHdr_q, stageHdr_d;
    logic [HDR_BYTES*8-1:0]   commitHdr_q;
    logic                     start_q;
    logic                     inFire;
    logic                     frameEnd;
    logic [31:0]              target;

    logic [31:0]              resTop;
    logic [31:0]              resWord;
    logic                     resPass;
    logic                     isRequest;
    logic                     resPass_q;
    logic [RES_BYTES*8-1:0]   resRec_q;
    logic                     reqPending_q, reqPending_d;
    logic                     reqPush;
    logic                     fifoPush;
    logic [RES_BYTES*8-1:0]   fifoDin;
    logic                     fifoPop;
    logic [RES_BYTES*8-1:0]   fifoDout;
    logic                     fifoFull;
    logic                     fifoEmpty;
    logic                     dropEvt;
    logic [15:0]              dropCnt_q;

    serState_e                state_q, state_d;
    logic [RP_W-1:0]          rdPtr_q, rdPtr_d;

    // ---------------- Header capture ----------------
    assign in_ready = rst_n;
    assign inFire   = in_valid && in_ready;
    assign frameEnd = inFire && (wrPtr_q == HDR_LAST);

    always_comb begin
        stageHdr_d = stageHdr_q;
        wrPtr_d    = wrPtr_q;
        if (inFire) begin
            stageHdr_d[8*wrPtr_q +: 8] = in_data;
            wrPtr_d = frameEnd ? '0 : wrPtr_q + 1'b1;
        end
    end

    // The committed copy only moves at a frame boundary so the mix sees a stable header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q     <= '0;
            stageHdr_q  <= '0;
            commitHdr_q <= '0;
            start_q     <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            stageHdr_q <= stageHdr_d;
            start_q    <= frameEnd;
            if (frameEnd) commitHdr_q <= stageHdr_d;
        end
    end

    assign hash_data = commitHdr_q[HASH_BYTES*8-1:0];
    assign job_id    = byteSwap32(commitHdr_q[JOBID_OFS*8 +: 32]);
    assign target    = byteSwap32(commitHdr_q[TGT_OFS*8 +: 32]);
    assign start     = start_q;

    // ---------------- Result filter and request ----------------
    assign resTop    = res_data[RES_BYTES*8-1 -: 32];
    assign resWord   = res_data[RES_BYTES*8-33 -: 32];
    assign resPass   = (CHECK_TARGET == 0) || ((resTop == 32'h0) && (resWord <= target));
    assign isRequest = res_valid && (res_nonce == LAST_NONCE) && (res_job == job_id);

    // Results win the FIFO write port; the request waits for a fully idle output path.
    assign reqPush  = reqPending_q && fifoEmpty && (state_q == IDLE) && !resPass_q;
    assign fifoPush = resPass_q || reqPush;
    assign fifoDin  = resPass_q ? resRec_q : '0;
    assign dropEvt  = resPass_q && fifoFull;

    always_comb begin
        reqPending_d = reqPending_q;
        if (reqPush)   reqPending_d = 1'b0;
        if (isRequest) reqPending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resPass_q    <= 1'b0;
            resRec_q     <= '0;
            reqPending_q <= 1'b0;
            dropCnt_q    <= '0;
        end else begin
            resPass_q    <= res_valid && resPass;
            reqPending_q <= reqPending_d;
            if (res_valid) resRec_q <= res_data;
            if (dropEvt && (dropCnt_q != 16'hFFFF)) dropCnt_q <= dropCnt_q + 1'b1;
        end
    end

    assign drop_cnt = dropCnt_q;

    sha_result_fifo #(
        .WIDTH (RES_BYTES*8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifoPush),
        .data_i  (fifoDin),
        .pop_i   (fifoPop),
        .data_o  (fifoDout),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // ---------------- Serializer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdPtr_q <= '0;
        end else begin
            state_q <= state_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdPtr_d = rdPtr_q;
        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    state_d = SEND;
                    rdPtr_d = '0;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (rdPtr_q == RES_LAST) begin
                        state_d = IDLE;
                        rdPtr_d = '0;
                    end else begin
                        rdPtr_d = rdPtr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The head record stays in the FIFO until its last byte leaves, which keeps out_data stable under stall.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 8'h00;
        if (state_q == SEND) begin
            out_valid = 1'b1;
            out_data  = fifoDout[8*rdPtr_q +: 8];
            out_last  = (rdPtr_q == RES_LAST);
        end
    end

    assign fifoPop = out_valid && out_ready && out_last;

endmodule

// File: tb/tb_sha_job_framer.sv
// Randomized scoreboard bench for sha_job_framer: header commit, filtering,
// work requests, overflow, backpressure and reset behaviour.
module tb_sha_job_framer;

    localparam int HDR   = 88;
    localparam int HASH  = 80;
    localparam int TGT   = 80;
    localparam int JOBID = 84;
    localparam int RES   = 32;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [HASH*8-1:0] hash_data;
    logic [31:0]       job_id;
    logic              start;
    logic              res_valid;
    logic [RES*8-1:0]  res_data;
    logic [31:0]       res_job;
    logic [31:0]       res_nonce;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_last;
    logic              out_ready;
    logic [15:0]       drop_cnt;

    always #5 clk = ~clk;

    sha_job_framer #(
        .HDR_BYTES    (HDR),
        .HASH_BYTES   (HASH),
        .TGT_OFS      (TGT),
        .JOBID_OFS    (JOBID),
        .RES_BYTES    (RES),
        .FIFO_DEPTH   (DEPTH),
        .CHECK_TARGET (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .hash_data (hash_data),
        .job_id    (job_id),
        .start     (start),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_job   (res_job),
        .res_nonce (res_nonce),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    int compared = 0;
    int mismatched = 0;
    logic [8:0] expQ[$];
    byte unsigned frameBuf[HDR];
    byte unsigned modelHdr[HDR];
    int expDrop = 0;
    int startCount = 0;
    int readyMode = 0;

    task automatic checkOutput(input string name, input logic [HASH*8-1:0] actual,
                               input logic [HASH*8-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] modelWord(input int ofs);
        return {modelHdr[ofs], modelHdr[ofs+1], modelHdr[ofs+2], modelHdr[ofs+3]};
    endfunction

    function automatic logic [31:0] recWord(input logic [RES*8-1:0] d, input int hiByte);
        return {d[hiByte*8 +: 8], d[(hiByte-1)*8 +: 8], d[(hiByte-2)*8 +: 8], d[(hiByte-3)*8 +: 8]};
    endfunction

    function automatic logic [RES*8-1:0] makeResult(input logic [31:0] top, input logic [31:0] word);
        logic [RES*8-1:0] d;
        for (int i = 0; i < RES; i++) d[i*8 +: 8] = 8'($urandom);
        for (int k = 0; k < 4; k++) begin
            d[(RES-1-k)*8 +: 8] = top[31-8*k -: 8];
            d[(RES-5-k)*8 +: 8] = word[31-8*k -: 8];
        end
        return d;
    endfunction

    task automatic pushRecord(input logic [RES*8-1:0] d);
        for (int i = 0; i < RES; i++) expQ.push_back({(i == RES-1), d[i*8 +: 8]});
    endtask

    // One result: the model decides pass/fail and request from the committed header.
    task automatic applyStimulus(input logic [RES*8-1:0] d, input logic [31:0] job,
                                 input logic [31:0] nonce, input bit canStore);
        if (recWord(d, RES-1) == 32'h0 && recWord(d, RES-5) <= modelWord(TGT)) begin
            if (canStore) pushRecord(d);
            else if (expDrop < 65535) expDrop++;
        end
        if (nonce == 32'hFFFFFFFF && job == modelWord(JOBID)) pushRecord('0);
        res_valid = 1'b1;
        res_data  = d;
        res_job   = job;
        res_nonce = nonce;
        @(posedge clk); #1;
        res_valid = 1'b0;
    endtask

    task automatic checkHeader();
        logic [HASH*8-1:0] expHash;
        for (int i = 0; i < HASH; i++) expHash[i*8 +: 8] = modelHdr[i];
        checkOutput("hash_data", hash_data, expHash);
        checkOutput("job_id", job_id, modelWord(JOBID));
    endtask

    task automatic streamBytes(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = frameBuf[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (n == HDR) begin
            for (int i = 0; i < HDR; i++) modelHdr[i] = frameBuf[i];
            @(negedge clk);
            checkOutput("start pulse", start, 1);
            @(negedge clk);
            checkOutput("start width", start, 0);
            checkHeader();
        end
    endtask

    task automatic checkReset();
        checkOutput("rst out_valid", out_valid, 0);
        checkOutput("rst out_last", out_last, 0);
        checkOutput("rst start", start, 0);
        checkOutput("rst drop_cnt", drop_cnt, 0);
        checkOutput("rst job_id", job_id, 0);
        checkOutput("rst hash_data", hash_data, 0);
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        while ((expQ.size() != 0 || out_valid) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxCycles) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain timeout: %0d bytes still expected, expected 0", expQ.size());
            expQ.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic settleReady(input int mode);
        readyMode = mode;
        repeat (2) @(posedge clk);
        #2;
    endtask

    // out_ready driver, changed only just after a rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (readyMode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                2:       out_ready = !out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on each transfer and checks stall stability.
    initial begin
        logic [7:0] held;
        bit         heldValid;
        logic [8:0] e;
        heldValid = 0;
        held = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                heldValid = 0;
                continue;
            end
            if (start) startCount++;
            if (out_valid && heldValid) checkOutput("stall stability", out_data, held);
            heldValid = 0;
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected byte: got %0h, expected no output", out_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("out_data", out_data, e[7:0]);
                    checkOutput("out_last", out_last, e[8]);
                end
            end else if (out_valid) begin
                held = out_data;
                heldValid = 1;
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s0;
        logic [31:0] tgt;
        logic [31:0] top;
        logic [31:0] word;
        int burst;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        res_valid = 1'b0;
        res_data = '0;
        res_job = '0;
        res_nonce = '0;
        for (int i = 0; i < HDR; i++) modelHdr[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkReset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("in_ready", in_ready, 1);

        // Header commit with a counting pattern
        s0 = startCount;
        for (int i = 0; i < HDR; i++) frameBuf[i] = 8'(i);
        streamBytes(HDR);
        checkOutput("start count", startCount - s0, 1);
        checkOutput("job_id pattern", job_id, 32'h54555657);
        checkOutput("hash byte 79", hash_data[79*8 +: 8], 8'h4F);

        // Difficulty filter around target 0x00001000
        for (int i = 0; i < HDR; i++) frameBuf[i] = 8'($urandom);
        frameBuf[TGT] = 8'h00; frameBuf[TGT+1] = 8'h00;
        frameBuf[TGT+2] = 8'h10; frameBuf[TGT+3] = 8'h00;
        streamBytes(HDR);
        applyStimulus(makeResult(32'h0, 32'h00000FFF), $urandom, $urandom & 32'h7FFFFFFF, 1);
        applyStimulus(makeResult(32'h0, 32'h00001000), $urandom, $urandom & 32'h7FFFFFFF, 1);
        applyStimulus(makeResult(32'h0, 32'h00001001), $urandom, $urandom & 32'h7FFFFFFF, 1);
        applyStimulus(makeResult(32'h00000001, 32'h0), $urandom, $urandom & 32'h7FFFFFFF, 1);
        waitDrain(1000);

        // Work request behind two queued records
        settleReady(1);
        applyStimulus(makeResult(32'h0, 32'h00000010), $urandom, $urandom & 32'h7FFFFFFF, 1);
        applyStimulus(makeResult(32'h0, 32'h00000020), $urandom, $urandom & 32'h7FFFFFFF, 1);
        applyStimulus(makeResult(32'hDEAD0000, 32'h0), modelWord(JOBID), 32'hFFFFFFFF, 1);
        repeat (10) @(posedge clk);
        #1;
        readyMode = 0;
        waitDrain(1000);

        // FIFO overflow with the output stalled
        settleReady(1);
        for (int i = 0; i < 20; i++)
            applyStimulus(makeResult(32'h0, $urandom_range(0, 32'h1000)), $urandom,
                          $urandom & 32'h7FFFFFFF, (i < DEPTH));
        repeat (3) @(negedge clk);
        checkOutput("drop_cnt overflow", drop_cnt, 16'(expDrop));
        readyMode = 0;
        waitDrain(3000);

        // Alternating backpressure
        readyMode = 2;
        for (int i = 0; i < 3; i++)
            applyStimulus(makeResult(32'h0, $urandom_range(0, 32'h1000)), $urandom,
                          $urandom & 32'h7FFFFFFF, 1);
        waitDrain(1000);

        // Random frames, targets and results under random backpressure
        readyMode = 3;
        for (int it = 0; it < 30; it++) begin
            if (it % 6 == 0) begin
                for (int i = 0; i < HDR; i++) frameBuf[i] = 8'($urandom);
                streamBytes(HDR);
            end
            burst = $urandom_range(1, 4);
            for (int b = 0; b < burst; b++) begin
                tgt = modelWord(TGT);
                top = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h1) : 32'h0;
                case ($urandom_range(0, 2))
                    0:       word = tgt - $urandom_range(0, 3);
                    1:       word = tgt + $urandom_range(1, 3);
                    default: word = $urandom;
                endcase
                applyStimulus(makeResult(top, word), $urandom, $urandom & 32'h7FFFFFFF, 1);
            end
            waitDrain(3000);
        end
        readyMode = 0;
        checkOutput("drop_cnt random", drop_cnt, 16'(expDrop));

        // Reset in the middle of a frame
        s0 = startCount;
        for (int i = 0; i < HDR; i++) frameBuf[i] = 8'($urandom);
        streamBytes(40);
        rst_n = 1'b0;
        #1;
        checkReset();
        for (int i = 0; i < HDR; i++) modelHdr[i] = 8'h00;
        expDrop = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < HDR; i++) frameBuf[i] = 8'($urandom);
        streamBytes(HDR);
        checkOutput("start after reset", startCount - s0, 1);

        repeat (20) @(negedge clk);
        checkOutput("drop_cnt final", drop_cnt, 16'(expDrop));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
